bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
//   Takes the 8-bit counter value and produces three BCD digits: hundreds, tens, ones.
//   Sits directly upstream of the display digit multiplexer.
//   The three digit outputs drive that multiplexer's three 4-bit data inputs.
//   Result registers hold the last complete value, so the display never shows a partial conversion.
// PARAMETERS
//   WIDTH  8  Binary input width. Legal range 1..9, because the result must fit in 3 BCD digits (max 999).
//   AUTO   1  1: a conversion starts automatically when bin_in differs from last_bin while idle.
//             0: a conversion starts only on the start input.
// PORTS
//   clk     in   1      System clock; all state updates on the rising edge.
//   rst     in   1      Asynchronous, active-high reset.
//   start   in   1      Request a conversion of bin_in; sampled only in IDLE.
//   bin_in  in   WIDTH  Binary value to convert; captured on the accepting edge.
//   busy    out  1      High while a conversion is in progress.
//   done    out  1      One-cycle pulse when the new digits are valid.
//   hun     out  4      BCD hundreds digit, registered.
//   ten     out  4      BCD tens digit, registered.
//   one     out  4      BCD ones digit, registered.
// BEHAVIOUR
//   Reset (async assert, rst high):
//     - State goes to IDLE; busy=0, done=0, hun=ten=one=0.
//     - Internal shift register cleared; last_bin cleared to 0.
//     - Takes effect immediately, including mid-conversion; the in-flight conversion is discarded.
//   FSM states: IDLE, SHIFT.
//   Trigger: in IDLE, trig = start | (AUTO & (bin_in != last_bin)).
//   IDLE -> SHIFT on the edge where trig=1:
//     - Capture bin_in into the binary shift field and into last_bin.
//     - Clear the 12-bit BCD field; set iteration count = 0; busy=1 from this edge.
//   SHIFT, on each edge:
//     - For each BCD nibble >= 5, add 3 to it (4-bit add, no carry out of the nibble).
//     - Then shift {bcd, bin} left by 1 bit.
//     - Increment the iteration count.
//   After the WIDTH-th SHIFT edge:
//     - hun/ten/one load the final BCD field.
//     - done=1 for exactly one cycle; busy=0; state returns to IDLE.
//   Latency:
//     - Accepting edge at N gives digits updated and done high at edge N+WIDTH.
//     - Minimum repeat interval is WIDTH+1 cycles.
//   During SHIFT:
//     - hun/ten/one keep their previous values.
//     - start and bin_in changes are ignored; no queueing.
//   A start or input change in the done cycle (already IDLE):
//     - Is accepted on the next edge.
//     - Back-to-back conversions therefore run with no dead cycles beyond the IDLE cycle.
//   Input outside the legal range:
//     - Cannot occur for WIDTH <= 9.
//     - WIDTH > 9 is a configuration error; flag it with an elaboration-time check.
//   Digits are always valid BCD (0..9); no digit ever exceeds 9.
// TESTING
//   1. Reset, then bin_in=0, start=1 for one cycle (AUTO=0).
//      -> busy for 8 cycles; done pulse at N+8; hun/ten/one = 0/0/0.
//   2. bin_in=255, start pulse.
//      -> at N+8: 2/5/5, done high for exactly one cycle; busy low at the same edge.
//   3. Sweep bin_in 0..255, one conversion each (AUTO=0, 9-cycle pacing).
//      -> every result matches a reference model (/100, /10%10, %10), e.g. 99 -> 0/9/9, 100 -> 1/0/0.
//   4. Start with bin_in=37; at N+3 pulse start with bin_in=200.
//      -> second request ignored; result 0/3/7 at N+8.
//      -> digits hold their old value until N+8.
//   5. Start with bin_in=128; assert rst at N+4 for one cycle.
//      -> immediately busy=0, done=0, digits 0/0/0; no done pulse follows.
//   6. AUTO=1: change bin_in from 0 to 42 and hold.
//      -> conversion starts with no start pulse; 0/4/2 with done.
//      -> no further conversion while bin_in is stable.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to three-digit BCD converter
module bin2bcd_seq #(
    parameter int WIDTH = 8,
    parameter int AUTO  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] bin_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       hun_o,
    output logic [3:0]       ten_o,
    output logic [3:0]       one_o
);

    generate
        if (WIDTH < 1 || WIDTH > 9) begin : g_bad_width
            $error("bin2bcd_seq: WIDTH must be in 1..9 so the result fits in three BCD digits");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       hun_q, hun_d;
    logic [3:0]       ten_q, ten_d;
    logic [3:0]       one_q, one_d;
    logic             done_q, done_d;
    logic             trig;
    logic [11:0]      adj;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hun_d   = hun_q;
        ten_d   = ten_q;
        one_d   = one_q;
        done_d  = 1'b0;
        trig    = start_i | ((AUTO != 0) && (bin_in_i != last_q));
        adj     = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = SHIFT;
                    bin_d   = bin_in_i;
                    last_d  = bin_in_i;
                    bcd_d   = 12'd0;
                    cnt_d   = 4'd0;
                end
            end
            SHIFT: begin
                bcd_d = {adj[10:0], bin_q[WIDTH-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 4'd1;
                // Digits only move on the final shift so the display never sees a partial value.
                if (cnt_q == LAST_ITER) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    hun_d   = bcd_d[11:8];
                    ten_d   = bcd_d[7:4];
                    one_d   = bcd_d[3:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bin_q   <= '0;
            last_q  <= '0;
            bcd_q   <= 12'd0;
            cnt_q   <= 4'd0;
            hun_q   <= 4'd0;
            ten_q   <= 4'd0;
            one_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            last_q  <= last_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hun_q   <= hun_d;
            ten_q   <= ten_d;
            one_q   <= one_d;
            done_q  <= done_d;
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = done_q;
    assign hun_o  = hun_q;
    assign ten_o  = ten_q;
    assign one_o  = one_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bin = 8'd0;
    logic       busy, done;
    logic [3:0] hun, ten, one;

    logic       start_a = 1'b0;
    logic [7:0] bin_a = 8'd0;
    logic       busy_a, done_a;
    logic [3:0] hun_a, ten_a, one_a;

    int checks = 0;
    int failures = 0;
    logic [11:0] exp_d = 12'h000;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(8), .AUTO(0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .bin_in_i(bin),
        .busy_o(busy), .done_o(done), .hun_o(hun), .ten_o(ten), .one_o(one)
    );

    bin2bcd_seq #(.WIDTH(8), .AUTO(1)) dut_auto (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .bin_in_i(bin_a),
        .busy_o(busy_a), .done_o(done_a), .hun_o(hun_a), .ten_o(ten_a), .one_o(one_a)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic convert(input int v);
        bin   = 8'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_done_low", 32'(done), 32'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            check("mid_busy", 32'(busy), 32'd1);
            check("mid_hold", 32'({hun, ten, one}), 32'(exp_d));
        end
        step();
        exp_d = ref_bcd(v);
        check("fin_done", 32'(done), 32'd1);
        check("fin_busy", 32'(busy), 32'd0);
        check("fin_digits", 32'({hun, ten, one}), 32'(exp_d));
    endtask

    initial begin
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_digits", 32'({hun, ten, one}), 32'h000);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);
        check("auto_idle_busy", 32'(busy_a), 32'd0);

        // 1: zero
        convert(0);
        check("zero_digits", 32'({hun, ten, one}), 32'h000);

        // 2: max value, single-cycle done
        convert(255);
        check("max_digits", 32'({hun, ten, one}), 32'h255);
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);

        // 3: full sweep with back-to-back pacing
        for (int v = 0; v < 256; v++) begin
            convert(v);
            if (v == 99)  check("sweep_99", 32'({hun, ten, one}), 32'h099);
            if (v == 100) check("sweep_100", 32'({hun, ten, one}), 32'h100);
        end

        // 4: request during SHIFT is ignored
        bin   = 8'd37;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        bin   = 8'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 4; i < 8; i++) begin
            step();
            check("ign_busy", 32'(busy), 32'd1);
            check("ign_hold", 32'({hun, ten, one}), 32'h255);
        end
        step();
        check("ign_done", 32'(done), 32'd1);
        check("ign_digits", 32'({hun, ten, one}), 32'h037);
        step();
        check("ign_no_requeue", 32'(busy), 32'd0);

        // 5: async reset mid-conversion
        bin   = 8'd128;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_digits", 32'({hun, ten, one}), 32'h000);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("arst_no_done", 32'(done), 32'd0);
        end
        check("arst_digits_kept", 32'({hun, ten, one}), 32'h000);

        // 6: AUTO=1 starts on input change only
        bin_a = 8'd42;
        step();
        check("auto_busy", 32'(busy_a), 32'd1);
        for (int i = 1; i < 8; i++) step();
        check("auto_busy_last", 32'(busy_a), 32'd1);
        step();
        check("auto_done", 32'(done_a), 32'd1);
        check("auto_digits", 32'({hun_a, ten_a, one_a}), 32'h042);
        for (int i = 0; i < 12; i++) begin
            step();
            check("auto_stable_busy", 32'(busy_a), 32'd0);
            check("auto_stable_done", 32'(done_a), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
